adrv9009_rhb1: RTL and testbench

ADRV9009_RHB1 -- requirements
Module: adrv9009_rhb1

---
 rtl/adrv9009_rhb1_pkg.sv | 12 +
 rtl/adrv9009_round_sat.sv | 29 ++
 rtl/adrv9009_rhb1.sv | 96 +++++++++
 tb/tb_adrv9009_rhb1.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adrv9009_rhb1_pkg.sv
// Shared constants for the RHB1 half-band decimator.
// Coefficients are integers on a 512 scale.
package adrv9009_rhb1_pkg;

   localparam int TAPS  = 11;
   localparam int ACC_W = 44;
   localparam int SHIFT = 9;
   localparam int RND   = 256;

   localparam int H [TAPS] = '{3, 0, -25, 0, 150, 256, 150, 0, -25, 0, 3};

endpackage

// File: rtl/adrv9009_round_sat.sv
// Round-half-up by 2^SHIFT, then clamp to the signed 32-bit range.
// Purely combinational; sits in front of the output register.
module adrv9009_round_sat
   import adrv9009_rhb1_pkg::*;
(
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [31:0]      res
);

   localparam logic signed [ACC_W-1:0] RND_C = ACC_W'(RND);
   localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(64'sh7FFFFFFF);
   localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-64'sh80000000);

   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] shr;

   assign sum = acc + RND_C;
   assign shr = sum >>> SHIFT;

   always_comb begin
      res = shr[31:0];
      if (shr > MAX_V) begin
         res = 32'sh7FFFFFFF;
      end else if (shr < MIN_V) begin
         res = 32'sh80000000;
      end
   end

endmodule

// File: rtl/adrv9009_rhb1.sv
// 11-tap half-band FIR with decimation by 2; three register stages
// after the delay line: pre-add, accumulate, round/saturate.
module adrv9009_rhb1
   import adrv9009_rhb1_pkg::*;
#(
   parameter int IN_W  = 32,
   parameter int OUT_W = 32
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [IN_W-1:0]  in,
   input  logic                    in_valid,
   output logic signed [OUT_W-1:0] out,
   output logic                    out_valid
);

   logic signed [IN_W-1:0]  x [TAPS];
   logic                    phase;
   logic                    v0, v1, v2;
   logic signed [IN_W:0]    p0, p2, p4;
   logic signed [IN_W-1:0]  c5;
   logic signed [ACC_W-1:0] acc;
   logic signed [31:0]      rs;

   // delay line and phase; v0 marks a window that must produce an output
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TAPS; i++) begin
            x[i] <= '0;
         end
         phase <= 1'b0;
         v0    <= 1'b0;
      end else begin
         v0 <= in_valid & phase;
         if (in_valid) begin
            x[0] <= in;
            for (int i = 1; i < TAPS; i++) begin
               x[i] <= x[i-1];
            end
            phase <= ~phase;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p0 <= '0;
         p2 <= '0;
         p4 <= '0;
         c5 <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= v0;
         if (v0) begin
            p0 <= {x[0][IN_W-1], x[0]} + {x[10][IN_W-1], x[10]};
            p2 <= {x[2][IN_W-1], x[2]} + {x[8][IN_W-1], x[8]};
            p4 <= {x[4][IN_W-1], x[4]} + {x[6][IN_W-1], x[6]};
            c5 <= x[5];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
         v2  <= 1'b0;
      end else begin
         v2 <= v1;
         if (v1) begin
            acc <= ACC_W'(H[0]) * ACC_W'(p0)
                 + ACC_W'(H[2]) * ACC_W'(p2)
                 + ACC_W'(H[4]) * ACC_W'(p4)
                 + ACC_W'(H[5]) * ACC_W'(c5);
         end
      end
   end

   adrv9009_round_sat u_rs (
      .acc (acc),
      .res (rs)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= v2;
         if (v2) begin
            out <= OUT_W'(rs);
         end
      end
   end

endmodule

// File: tb/tb_adrv9009_rhb1.sv
// Directed bench for the RHB1 decimator: values, pulse timing,
// saturation, rounding ties and reset behaviour.
module tb_adrv9009_rhb1;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [31:0] in;
   logic               in_valid;
   logic signed [31:0] out;
   logic               out_valid;

   int total = 0;
   int bad   = 0;
   int edge_n = 0;
   int n_acc = 0;
   logic signed [31:0] got [$];
   int got_e [$];
   int exp_e [$];

   localparam logic signed [31:0] M = 32'sh7FFFFFFF;

   adrv9009_rhb1 #(.IN_W(32), .OUT_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (in),
      .in_valid  (in_valid),
      .out       (out),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   // pulse recorder, sampled 1 time unit after each rising edge
   always @(posedge clk) begin
      edge_n = edge_n + 1;
      #1;
      if (out_valid === 1'b1) begin
         got.push_back(out);
         got_e.push_back(edge_n);
      end
   end

   task automatic clear_model();
      got.delete();
      got_e.delete();
      exp_e.delete();
      n_acc = 0;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      clear_model();
   endtask

   task automatic send(input logic signed [31:0] s, input int gap);
      @(negedge clk);
      in = s;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      n_acc++;
      if (n_acc % 2 == 0) exp_e.push_back(edge_n + 3);
      if (gap > 0) begin
         @(negedge clk);
         in_valid = 1'b0;
         in = 32'sh5A5A5A5A;
         repeat (gap - 1) @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0;
      in = 32'sh13572468;
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (out !== 32'sd0) begin
         bad++;
         $display("FAIL reset_out: got %0d want 0", out);
      end
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_valid: got %b want 0", out_valid);
      end
   endtask

   task automatic test_impulse_ph1();
      logic signed [31:0] ev [7] = '{3, -25, 150, 150, -25, 3, 0};
      reset_dut();
      send(0, 0);
      send(512, 0);
      repeat (12) send(0, 0);
      idle(6);
      total++;
      if (got.size() !== 7) begin
         bad++;
         $display("FAIL imp1_count: got %0d want 7", got.size());
      end
      for (int i = 0; i < 7 && i < got.size(); i++) begin
         total++;
         if (got[i] !== ev[i]) begin
            bad++;
            $display("FAIL imp1_val[%0d]: got %0d want %0d", i, got[i], ev[i]);
         end
         total++;
         if (got_e[i] !== exp_e[i]) begin
            bad++;
            $display("FAIL imp1_edge[%0d]: got %0d want %0d", i, got_e[i], exp_e[i]);
         end
      end
   endtask

   task automatic test_impulse_ph0();
      logic signed [31:0] ev [6] = '{0, 0, 256, 0, 0, 0};
      reset_dut();
      send(512, 0);
      repeat (11) send(0, 0);
      idle(6);
      total++;
      if (got.size() !== 6) begin
         bad++;
         $display("FAIL imp0_count: got %0d want 6", got.size());
      end
      for (int i = 0; i < 6 && i < got.size(); i++) begin
         total++;
         if (got[i] !== ev[i]) begin
            bad++;
            $display("FAIL imp0_val[%0d]: got %0d want %0d", i, got[i], ev[i]);
         end
      end
   endtask

   task automatic run_dc(input string nm, input int gap);
      logic signed [31:0] ev [8] = '{6, -44, 768, 1068, 1018, 1024, 1024, 1024};
      reset_dut();
      repeat (16) send(1024, gap);
      idle(6);
      total++;
      if (got.size() !== 8) begin
         bad++;
         $display("FAIL %s_count: got %0d want 8", nm, got.size());
      end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         total++;
         if (got[i] !== ev[i]) begin
            bad++;
            $display("FAIL %s_val[%0d]: got %0d want %0d", nm, i, got[i], ev[i]);
         end
         total++;
         if (got_e[i] !== exp_e[i]) begin
            bad++;
            $display("FAIL %s_edge[%0d]: got %0d want %0d", nm, i, got_e[i], exp_e[i]);
         end
      end
      total++;
      if (out !== 32'sd1024 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL %s_hold: got %0d/%b want 1024/0", nm, out, out_valid);
      end
   endtask

   task automatic test_dc_gaps();
      run_dc("dc_gap", 3);
   endtask

   task automatic test_back_to_back();
      run_dc("dc_b2b", 0);
   endtask

   task automatic run_sat(input string nm, input logic signed [31:0] seq [12],
                          input logic signed [31:0] want);
      reset_dut();
      for (int i = 0; i < 12; i++) send(seq[i], 0);
      idle(6);
      total++;
      if (got.size() !== 6) begin
         bad++;
         $display("FAIL %s_count: got %0d want 6", nm, got.size());
      end else begin
         total++;
         if (got[5] !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got[5], want);
         end
      end
   endtask

   task automatic test_saturation();
      logic signed [31:0] sp [12] = '{0, M, 0, -M, 0, M, M, M, 0, -M, 0, M};
      logic signed [31:0] sn [12] = '{0, -M, 0, M, 0, -M, -M, -M, 0, M, 0, -M};
      logic signed [31:0] sc [12] = '{M, M, M, M, M, M, M, M, M, M, M, M};
      run_sat("sat_pos", sp, 32'sh7FFFFFFF);
      run_sat("sat_neg", sn, 32'sh80000000);
      run_sat("sat_const", sc, 32'sh7FFFFFFF);
   endtask

   task automatic test_round_ties();
      logic signed [31:0] tp [12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      logic signed [31:0] tn [12] = '{-1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      reset_dut();
      for (int i = 0; i < 6; i++) send(tp[i], 0);
      idle(6);
      total++;
      if (got.size() !== 3 || got[2] !== 32'sd1) begin
         bad++;
         $display("FAIL tie_pos: got %0d (n=%0d) want 1", got[2], got.size());
      end
      reset_dut();
      for (int i = 0; i < 6; i++) send(tn[i], 0);
      idle(6);
      total++;
      if (got.size() !== 3 || got[2] !== 32'sd0) begin
         bad++;
         $display("FAIL tie_neg: got %0d (n=%0d) want 0", got[2], got.size());
      end
   endtask

   task automatic test_reset_mid();
      reset_dut();
      send(100, 0);
      send(200, 0);
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b1;
      in = 32'sd777;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b0;
      clear_model();
      repeat (4) @(posedge clk);
      #2;
      total++;
      if (got.size() !== 0) begin
         bad++;
         $display("FAIL rst_mid_pulse: got %0d pulses want 0", got.size());
      end
      total++;
      if (out !== 32'sd0) begin
         bad++;
         $display("FAIL rst_mid_out: got %0d want 0", out);
      end
      send(0, 0);
      send(512, 0);
      idle(6);
      total++;
      if (got.size() !== 1) begin
         bad++;
         $display("FAIL rst_mid_count: got %0d want 1", got.size());
      end else begin
         total++;
         if (got[0] !== 32'sd3 || got_e[0] !== exp_e[0]) begin
            bad++;
            $display("FAIL rst_mid_first: got %0d@%0d want 3@%0d",
                     got[0], got_e[0], exp_e[0]);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      in = '0;
      test_reset();
      test_impulse_ph1();
      test_impulse_ph0();
      test_dc_gaps();
      test_back_to_back();
      test_saturation();
      test_round_ties();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
